// File: rtl/uop_replay_sequencer_pkg.sv
// Shared types and sizing for the uop replay sequencer and its FIFO.
package uop_replay_sequencer_pkg;

    localparam int UOP_ADDR_W     = 6;
    localparam int UOP_DATA_W     = 32;
    localparam int UOP_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Pointer width for a ring of 'depth' slots; a single-slot ring still needs one bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uop_replay_sequencer_if.sv
// Cache read port plus issue-side uop stream, bundled for the sequencer.
interface uop_replay_sequencer_if
    import uop_replay_sequencer_pkg::*;
#(
    parameter int ADDR_W = UOP_ADDR_W,
    parameter int DATA_W = UOP_DATA_W
) ();

    logic              cache_rd_en;
    logic [ADDR_W-1:0] cache_rd_addr;
    logic [DATA_W-1:0] cache_rd_data;
    logic              uop_valid;
    logic              uop_ready;
    logic [DATA_W-1:0] uop_data;
    logic              uop_last;

    modport master (
        output cache_rd_en, cache_rd_addr,
        input  cache_rd_data,
        output uop_valid, uop_data, uop_last,
        input  uop_ready
    );

    modport slave (
        input  cache_rd_en, cache_rd_addr,
        output cache_rd_data,
        input  uop_valid, uop_data, uop_last,
        output uop_ready
    );

endinterface

// File: rtl/uop_sync_fifo.sv
// Synchronous ring FIFO with occupancy count and a flush that empties it in one cycle.
module uop_sync_fifo
    import uop_replay_sequencer_pkg::*;
#(
    parameter int WIDTH = UOP_DATA_W + 1,
    parameter int DEPTH = UOP_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W     = fifo_ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign pop_ok_s  = pop && (count_q != CNT_ZERO);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s = push && ((count_q != DEPTH_CNT) || pop_ok_s);
    assign pop_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next pointers and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    uop_sync_fifo_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop_ok (pop_ok_s),
        .count  (count_q)
    );

endmodule

// File: rtl/uop_sync_fifo_chk.sv
// Occupancy checks for uop_sync_fifo; holds only assertions.
module uop_sync_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             push,
    input logic             pop_ok,
    input logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // A push into a full FIFO without a matching pop would lose an entry.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count == DEPTH_CNT) && !pop_ok));

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count <= DEPTH_CNT);

endmodule

// File: rtl/uop_replay_sequencer.sv
// Streams a window of the uop cache, repeated a programmable number of times,
// into a valid/ready issue stream buffered by a small FIFO.
module uop_replay_sequencer
    import uop_replay_sequencer_pkg::*;
#(
    parameter int ADDR_W     = UOP_ADDR_W,
    parameter int DATA_W     = UOP_DATA_W,
    parameter int FIFO_DEPTH = UOP_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W:0]       length,
    input  logic [3:0]            repeat_cnt,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    uop_replay_sequencer_if.master bus
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [3:0]        PASS_ZERO = 4'd0;
    localparam logic [3:0]        PASS_ONE  = 4'd1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   offset_q, offset_d;
    logic [3:0]        rep_q, rep_d;
    logic [3:0]        pass_q, pass_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;

    logic              rd_en_s;
    logic              space_s;
    logic              off_end_s;
    logic              pass_end_s;
    logic              drain_empty_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [DATA_W:0]   fifo_head_s;

    // Reads already in flight count against FIFO space, so a push never finds it overfull.
    assign space_s    = (int'(fifo_count_s) + int'(inflight_q)) < FIFO_DEPTH;
    assign off_end_s  = (offset_q + LEN_ONE) == len_q;
    assign pass_end_s = (pass_q == rep_q);

    // Retiring now empties the FIFO with nothing left to arrive, so done lands right after the last transfer.
    assign drain_empty_s = !inflight_q &&
                           ((fifo_count_s == CNT_ZERO) ||
                            ((fifo_count_s == CNT_ONE) && fifo_pop_s));

    // Next-state, counters and read issue; abort overrides every other event.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        rep_d    = rep_q;
        offset_d = offset_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        rd_en_s  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (length != LEN_ZERO)) begin
                        state_d  = ST_RUN;
                        base_d   = start_addr;
                        len_d    = length;
                        rep_d    = repeat_cnt;
                        offset_d = LEN_ZERO;
                        pass_d   = PASS_ZERO;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rd_en_s = space_s;
                    if (space_s && off_end_s) begin
                        offset_d = LEN_ZERO;
                        pass_d   = pass_q + PASS_ONE;
                        state_d  = pass_end_s ? ST_DRAIN : ST_RUN;
                    end else if (space_s) begin
                        offset_d = offset_q + LEN_ONE;
                    end else begin
                        offset_d = offset_q;
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty_s) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        inflight_d      = rd_en_s;
        inflight_last_d = rd_en_s && off_end_s && pass_end_s;
    end

    // State, command and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            base_q          <= ADDR_ZERO;
            len_q           <= LEN_ZERO;
            rep_q           <= PASS_ZERO;
            offset_q        <= LEN_ZERO;
            pass_q          <= PASS_ZERO;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            rep_q           <= rep_d;
            offset_q        <= offset_d;
            pass_q          <= pass_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    assign fifo_push_s = inflight_q && !abort;
    assign fifo_pop_s  = bus.uop_valid && bus.uop_ready;

    uop_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (fifo_push_s),
        .push_data ({inflight_last_q, bus.cache_rd_data}),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .count     (fifo_count_s)
    );

    assign busy              = (state_q != ST_IDLE);
    assign done              = done_q;
    assign bus.cache_rd_en   = rd_en_s;
    assign bus.cache_rd_addr = rd_en_s ? (base_q + offset_q[ADDR_W-1:0]) : ADDR_ZERO;
    assign bus.uop_valid     = (fifo_count_s != CNT_ZERO);
    assign bus.uop_data      = bus.uop_valid ? fifo_head_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign bus.uop_last      = bus.uop_valid && fifo_head_s[DATA_W];

endmodule

// File: tb/tb_uop_replay_sequencer.sv
// Randomised scoreboard bench for uop_replay_sequencer with a behavioural cache and stream model.
module tb_uop_replay_sequencer;
    import uop_replay_sequencer_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic [5:0]  start_addr = 6'd0;
    logic [6:0]  length     = 7'd0;
    logic [3:0]  repeat_cnt = 4'd0;
    logic        busy;
    logic        done;

    logic [31:0] cmem [64];
    exp_t        exp_q [$];
    int          checks     = 0;
    int          errors     = 0;
    int          done_seen  = 0;
    int          ready_mode = 0;
    logic        ready_manual = 1'b0;
    bit          model_idle = 1'b1;

    uop_replay_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    uop_replay_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .repeat_cnt (repeat_cnt),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    // Uop cache: synchronous read, data the cycle after the enable.
    always @(posedge clk) begin
        if (bus.cache_rd_en) bus.cache_rd_data <= cmem[bus.cache_rd_addr];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, 64'({busy, done, bus.cache_rd_en, bus.uop_valid, bus.uop_last,
                       bus.cache_rd_addr, bus.uop_data}), 64'd0);
    endtask

    // Consumer ready: always, random, or test-controlled.
    initial begin : ready_drv
        bus.uop_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.uop_ready = 1'b1;
                1:       bus.uop_ready = 1'($urandom_range(0, 1));
                default: bus.uop_ready = ready_manual;
            endcase
        end
    end

    // Monitor: scoreboard pops, stall stability, done timing, FIFO bound.
    initial begin : monitor
        exp_t        e;
        logic        xfer;
        logic        prev_valid     = 1'b0;
        logic        prev_ready     = 1'b0;
        logic        prev_abort     = 1'b0;
        logic        prev_last      = 1'b0;
        logic        prev_xfer_last = 1'b0;
        logic [31:0] prev_data      = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid     = 1'b0;
                prev_abort     = 1'b0;
                prev_xfer_last = 1'b0;
            end else begin
                check("done_timing", 64'(done), 64'(prev_xfer_last));
                if (done) begin
                    done_seen++;
                    model_idle = 1'b1;
                    check("busy_at_done", 64'(busy), 64'd0);
                end
                if (prev_valid && !prev_ready && !prev_abort)
                    check("stall_hold", {30'd0, bus.uop_valid, bus.uop_last, bus.uop_data},
                          {30'd0, 1'b1, prev_last, prev_data});
                check("fifo_bound", 64'(int'(dut.fifo_count_s) > DEPTH), 64'd0);
                xfer = bus.uop_valid && bus.uop_ready;
                prev_xfer_last = 1'b0;
                if (xfer) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_uop actual=%0h expected=none", bus.uop_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("uop", {31'd0, bus.uop_last, bus.uop_data}, {31'd0, e.last, e.data});
                        prev_xfer_last = e.last;
                    end
                end
                prev_valid = bus.uop_valid;
                prev_ready = bus.uop_ready;
                prev_abort = abort;
                prev_last  = bus.uop_last;
                prev_data  = bus.uop_data;
            end
        end
    end

    // Start command; the model accepts it only when idle with a non-zero length.
    task automatic issue(input int a, input int len, input int rep);
        bit acc;
        @(posedge clk);
        #2;
        start      = 1'b1;
        start_addr = 6'(a);
        length     = 7'(len);
        repeat_cnt = 4'(rep);
        acc        = model_idle && (len != 0);
        @(posedge clk);
        #2;
        start = 1'b0;
        if (acc) begin
            model_idle = 1'b0;
            for (int p = 0; p <= rep; p++) begin
                for (int o = 0; o < len; o++) begin
                    exp_q.push_back('{data: cmem[(a + o) % 64], last: (p == rep) && (o == len - 1)});
                end
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_seen;
        int i  = 0;
        while ((i < budget) && (done_seen == d0)) begin
            @(posedge clk);
            i++;
        end
        if (done_seen == d0) check("done_timeout", 64'(done_seen - d0), 64'd1);
    endtask

    task automatic wait_valid(input int budget);
        int i = 0;
        while ((i < budget) && !bus.uop_valid) begin
            @(negedge clk);
            i++;
        end
        if (!bus.uop_valid) check("valid_timeout", 64'(bus.uop_valid), 64'd1);
    endtask

    initial begin : main
        int d0;
        for (int i = 0; i < 64; i++) cmem[i] = 32'hA000_0000 + 32'(i);

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #3 reset = 1'b1;

        // Basic window, first-read and first-valid latency.
        ready_mode = 0;
        issue(5, 4, 0);
        @(negedge clk);
        check("first_read", 64'({busy, bus.cache_rd_en, bus.cache_rd_addr}), 64'({1'b1, 1'b1, 6'd5}));
        @(negedge clk);
        check("valid_cycle2", 64'(bus.uop_valid), 64'd0);
        @(negedge clk);
        check("valid_cycle3", 64'(bus.uop_valid), 64'd1);
        wait_done(40);
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // Address wrap with a repeat.
        issue(62, 4, 1);
        wait_done(40);
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // Random backpressure.
        ready_mode = 1;
        issue(10, 16, 0);
        wait_done(300);
        issue(50, 16, 2);
        wait_done(600);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Abort with the third uop at the head and ready low.
        ready_mode   = 2;
        ready_manual = 1'b0;
        issue(20, 10, 0);
        repeat (2) begin
            wait_valid(20);
            ready_manual = 1'b1;
            @(negedge clk);
            ready_manual = 1'b0;
        end
        repeat (3) @(negedge clk);
        d0 = done_seen;
        @(posedge clk);
        #2;
        abort = 1'b1;
        exp_q.delete();
        model_idle = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", 64'({busy, bus.uop_valid}), 64'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", 64'(done_seen - d0), 64'd0);
        ready_mode = 0;
        issue(33, 3, 0);
        wait_done(40);
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // Zero length, start with abort in idle, start while busy.
        issue(7, 0, 0);
        @(negedge clk);
        check("len0_idle", 64'({busy, bus.cache_rd_en}), 64'd0);
        @(posedge clk);
        #2;
        start = 1'b1; abort = 1'b1; start_addr = 6'd3; length = 7'd5;
        @(posedge clk);
        #2;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", 64'(busy), 64'd0);
        issue(30, 12, 2);
        repeat (5) @(posedge clk);
        issue(0, 5, 0);
        @(negedge clk);
        check("busy_ignore", 64'(busy), 64'd1);
        wait_done(100);
        check("t5_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-run, then a single-uop command.
        ready_mode = 1;
        issue(40, 30, 3);
        repeat (20) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        model_idle = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        ready_mode = 0;
        issue(9, 1, 0);
        wait_done(30);
        check("t6_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
